// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: drives register-file read selects, forwards from MEM,
// inserts load-use bubbles and registers the decoded instruction for execute.
module id_ex_stage #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 3,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic [WIDTH-1:0]   id_imm,
  output logic [REGBITS-1:0] rf_read1sel,
  output logic [REGBITS-1:0] rf_read2sel,
  input  logic [WIDTH-1:0]   rf_read1data,
  input  logic [WIDTH-1:0]   rf_read2data,
  input  logic               mem_regwrite,
  input  logic [REGBITS-1:0] mem_rd,
  input  logic [WIDTH-1:0]   mem_result,
  input  logic               flush,
  input  logic               ex_stall,
  output logic               id_stall,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   ex_op1,
  output logic [WIDTH-1:0]   ex_op2,
  output logic [WIDTH-1:0]   ex_imm,
  output logic [REGBITS-1:0] ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic [CNTW-1:0]    bubble_cnt
);

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic [REGBITS-1:0] rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic [CNTW-1:0]    bubble_q, bubble_d;

  logic               hazard;
  logic [WIDTH-1:0]   fwd1, fwd2;

  assign rf_read1sel = id_rs;
  assign rf_read2sel = id_rt;

  // A load sitting in EX cannot supply its data until it reaches MEM next cycle.
  assign hazard = id_valid & valid_q & memread_q & regwrite_q &
                  ((id_use_rs & (id_rs == rd_q)) | (id_use_rt & (id_rt == rd_q)));
  assign id_stall = (hazard | ex_stall) & ~flush;

  assign fwd1 = (mem_regwrite && (mem_rd == id_rs)) ? mem_result : rf_read1data;
  assign fwd2 = (mem_regwrite && (mem_rd == id_rt)) ? mem_result : rf_read2data;

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latch).
    valid_d    = valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    bubble_d   = bubble_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
    end else if (ex_stall) begin
      // hold everything; a pending hazard is not counted while execute is stalled
    end else if (hazard) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      if (bubble_q != '1) bubble_d = bubble_q + CNTW'(1);
    end else begin
      valid_d    = id_valid;
      regwrite_d = id_regwrite & id_valid;
      memread_d  = id_memread & id_valid;
      op1_d      = fwd1;
      op2_d      = fwd2;
      imm_d      = id_imm;
      rd_d       = id_rd;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      bubble_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      bubble_q   <= bubble_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_op1      = op1_q;
  assign ex_op2      = op2_q;
  assign ex_imm      = imm_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected ID/EX latch contents are queued
// when stimulus is driven and compared after the capturing clock edge.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 3;
  // Narrow counter so saturation is reachable: a bubble needs two cycles.
  localparam int CNTW    = 8;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rd;
    logic               regwrite;
    logic               memread;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [REGBITS-1:0] id_rs, id_rt, id_rd, mem_rd;
  logic [REGBITS-1:0] rf_read1sel, rf_read2sel;
  logic [WIDTH-1:0] id_imm, rf_read1data, rf_read2data, mem_result;
  logic mem_regwrite, flush, ex_stall, id_stall;
  logic ex_valid, ex_regwrite, ex_memread;
  logic [WIDTH-1:0] ex_op1, ex_op2, ex_imm;
  logic [REGBITS-1:0] ex_rd;
  logic [CNTW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;
  ex_t exp_q[$];
  ex_t act, exp;

  id_ex_stage #(.WIDTH(WIDTH), .REGBITS(REGBITS), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_imm(id_imm),
    .rf_read1sel(rf_read1sel), .rf_read2sel(rf_read2sel),
    .rf_read1data(rf_read1data), .rf_read2data(rf_read2data),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .flush(flush), .ex_stall(ex_stall), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  function automatic ex_t latch_now();
    return '{ex_valid, ex_op1, ex_op2, ex_imm, ex_rd, ex_regwrite, ex_memread};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_regwrite = 0; id_memread = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0;
    rf_read1data = 0; rf_read2data = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    flush = 0; ex_stall = 0;
  endtask

  task automatic drive_instr(input logic [REGBITS-1:0] rs, rt, rd,
                             input logic use_rs, use_rt, rw, mr,
                             input logic [WIDTH-1:0] imm, d1, d2);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_use_rs = use_rs; id_use_rt = use_rt; id_regwrite = rw; id_memread = mr;
    id_imm = imm; rf_read1data = d1; rf_read2data = d2;
  endtask

  // Advance one edge and compare the latch with the oldest queued expectation.
  task automatic tick_and_compare(input string name);
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = exp_q.pop_front();
      act = latch_now();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s latch got=%h want=%h", name, act, exp);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #3;
    checks++;
    if (latch_now() !== ex_t'(0) || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL reset_initial got=%h cnt=%h want=0", latch_now(), bubble_cnt);
    end
    rst = 1;
    tick();
    drive_instr(3'd1, 3'd2, 3'd7, 1, 1, 1, 1, 16'h0042, 16'h7777, 16'h8888);
    exp_q.push_back('{1'b1, 16'h7777, 16'h8888, 16'h0042, 3'd7, 1'b1, 1'b1});
    tick_and_compare("reset_preload");
    ex_stall = 1;
    exp_q.push_back('{1'b1, 16'h7777, 16'h8888, 16'h0042, 3'd7, 1'b1, 1'b1});
    tick_and_compare("reset_prestall");
    #3 rst = 0;
    #1;
    checks++;
    if (latch_now() !== ex_t'(0) || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL reset_midstall got=%h cnt=%h want=0", latch_now(), bubble_cnt);
    end
    #1 rst = 1;
    idle();
    exp_q.push_back('0);
    tick_and_compare("reset_release_idle");
  endtask

  task automatic test_plain_load();
    idle();
    drive_instr(3'd1, 3'd2, 3'd5, 1, 1, 1, 0, 16'h0007, 16'h1234, 16'hABCD);
    #1;
    checks++;
    if (id_stall !== 1'b0 || rf_read1sel !== 3'd1 || rf_read2sel !== 3'd2) begin
      errors++;
      $display("FAIL plain_comb stall=%b sel1=%0d sel2=%0d want 0/1/2", id_stall, rf_read1sel, rf_read2sel);
    end
    exp_q.push_back('{1'b1, 16'h1234, 16'hABCD, 16'h0007, 3'd5, 1'b1, 1'b0});
    tick_and_compare("plain_load");
    // id_valid=0 loads a bubble even if other decode fields are set
    id_valid = 0;
    exp_q.push_back('{1'b0, 16'h1234, 16'hABCD, 16'h0007, 3'd5, 1'b0, 1'b0});
    tick_and_compare("invalid_slot");
  endtask

  task automatic test_mem_forward();
    idle();
    drive_instr(3'd3, 3'd4, 3'd6, 1, 1, 1, 0, 16'h0001, 16'h1111, 16'h2222);
    mem_regwrite = 1; mem_rd = 3'd3; mem_result = 16'h00FF;
    exp_q.push_back('{1'b1, 16'h00FF, 16'h2222, 16'h0001, 3'd6, 1'b1, 1'b0});
    tick_and_compare("fwd_rs");
    mem_rd = 3'd4; mem_result = 16'h0A0A;
    exp_q.push_back('{1'b1, 16'h1111, 16'h0A0A, 16'h0001, 3'd6, 1'b1, 1'b0});
    tick_and_compare("fwd_rt");
    mem_regwrite = 0;
    exp_q.push_back('{1'b1, 16'h1111, 16'h2222, 16'h0001, 3'd6, 1'b1, 1'b0});
    tick_and_compare("fwd_disabled");
    drive_instr(3'd0, 3'd0, 3'd1, 1, 1, 1, 0, 16'h0002, 16'h3333, 16'h4444);
    mem_regwrite = 1; mem_rd = 3'd0; mem_result = 16'h5A5A;
    exp_q.push_back('{1'b1, 16'h5A5A, 16'h5A5A, 16'h0002, 3'd1, 1'b1, 1'b0});
    tick_and_compare("fwd_r0");
  endtask

  task automatic test_load_use();
    logic [CNTW-1:0] b0;
    idle();
    drive_instr(3'd7, 3'd6, 3'd2, 0, 0, 1, 1, 16'h0020, 16'h0C0C, 16'h0D0D);
    exp_q.push_back('{1'b1, 16'h0C0C, 16'h0D0D, 16'h0020, 3'd2, 1'b1, 1'b1});
    tick_and_compare("lu_load");
    b0 = bubble_cnt;
    drive_instr(3'd2, 3'd5, 3'd3, 0, 1, 1, 0, 16'h0030, 16'h0000, 16'h5555);
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_unused_rs stall=%b want 0", id_stall);
    end
    id_valid = 0; id_use_rs = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_invalid stall=%b want 0", id_stall);
    end
    id_valid = 1;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall stall=%b want 1", id_stall);
    end
    exp_q.push_back('{1'b0, 16'h0C0C, 16'h0D0D, 16'h0020, 3'd2, 1'b0, 1'b0});
    tick_and_compare("lu_bubble");
    checks++;
    if (bubble_cnt !== b0 + CNTW'(1)) begin
      errors++;
      $display("FAIL lu_count got=%h want=%h", bubble_cnt, b0 + CNTW'(1));
    end
    mem_regwrite = 1; mem_rd = 3'd2; mem_result = 16'hBEEF;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release stall=%b want 0", id_stall);
    end
    exp_q.push_back('{1'b1, 16'hBEEF, 16'h5555, 16'h0030, 3'd3, 1'b1, 1'b0});
    tick_and_compare("lu_forward");
  endtask

  task automatic test_stall_flush();
    logic [CNTW-1:0] b0;
    idle();
    drive_instr(3'd0, 3'd0, 3'd4, 0, 0, 1, 1, 16'h0010, 16'h4444, 16'h5555);
    exp_q.push_back('{1'b1, 16'h4444, 16'h5555, 16'h0010, 3'd4, 1'b1, 1'b1});
    tick_and_compare("sf_load");
    b0 = bubble_cnt;
    drive_instr(3'd4, 3'd1, 3'd5, 1, 0, 1, 0, 16'h0099, 16'h9999, 16'h9898);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++;
        $display("FAIL sf_stall_comb cycle %0d stall=%b want 1", i, id_stall);
      end
      rf_read1data = rf_read1data + 16'h0101;
      exp_q.push_back('{1'b1, 16'h4444, 16'h5555, 16'h0010, 3'd4, 1'b1, 1'b1});
      tick_and_compare("sf_hold");
      checks++;
      if (bubble_cnt !== b0) begin
        errors++;
        $display("FAIL sf_count cycle %0d got=%h want=%h", i, bubble_cnt, b0);
      end
    end
    flush = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL sf_flush_comb stall=%b want 0", id_stall);
    end
    exp_q.push_back('{1'b0, 16'h4444, 16'h5555, 16'h0010, 3'd4, 1'b0, 1'b0});
    tick_and_compare("sf_flush");
    checks++;
    if (bubble_cnt !== b0) begin
      errors++;
      $display("FAIL sf_flush_count got=%h want=%h", bubble_cnt, b0);
    end
  endtask

  task automatic test_saturation();
    int n;
    idle();
    #2 rst = 0;
    #2 rst = 1;
    n = 0;
    for (int i = 0; i < int'(CMAX) + 2; i++) begin
      drive_instr(3'd0, 3'd0, 3'd1, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000);
      tick();
      drive_instr(3'd1, 3'd1, 3'd2, i[0] == 1'b0, i[0] == 1'b1, 1, 0,
                  16'h0000, 16'h0000, 16'h0000);
      tick();
      n = (n < int'(CMAX)) ? n + 1 : n;
      checks++;
      if (bubble_cnt !== CNTW'(n) || ex_valid !== 1'b0) begin
        errors++;
        $display("FAIL sat_count pair %0d got=%h valid=%b want=%h valid=0", i, bubble_cnt, ex_valid, CNTW'(n));
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_plain_load();
    test_mem_forward();
    test_load_use();
    test_stall_flush();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
